// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD refresh sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {PWRUP, LOAD, START, WAIT, DELAY, IDLE} lcd_state_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] ADDR_LINE1   = 8'h80;
  localparam logic [7:0] ADDR_LINE2   = 8'hC0;

  localparam int         STEP_COUNT     = 38;
  localparam logic [5:0] STEP_INIT_LAST = 6'd3;
  localparam logic [5:0] STEP_LINE1     = 6'd4;
  localparam logic [5:0] STEP_LINE2     = 6'd21;
  localparam logic [5:0] STEP_LAST      = 6'(STEP_COUNT - 1);

  // Character steps 5-20 map to buffer 0-15, steps 22-37 to buffer 16-31.
  function automatic logic [4:0] step_char_addr(input logic [5:0] step);
    if (step < STEP_LINE2) return 5'(step - 6'd5);
    return 5'(step - 6'd6);
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// 32x8 character buffer: synchronous write, asynchronous read, powers up as spaces.
module lcd_char_ram (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [32] = '{default: 8'h20};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_sequencer.sv
// Walks the fixed init + two-line refresh list, handing one byte at a time to an LCD write controller.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES = 750000,
  parameter int DELAY_CYCLES   = 100000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iWR_EN,
  input  logic [4:0] iWR_ADDR,
  input  logic [7:0] iWR_DATA,
  input  logic       iREFRESH,
  output logic       oBUSY,
  output logic       oINIT_DONE,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  input  logic       iLCD_DONE
);

  localparam logic [19:0] PWR_LAST = 20'(POWERUP_CYCLES - 1);
  localparam logic [19:0] DLY_LAST = 20'(DELAY_CYCLES - 1);

  lcd_state_e  state, state_next;
  logic [19:0] cnt;
  logic [5:0]  step;
  logic        pending;
  logic        init_done;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        done_q, done_qq;
  logic        done_rise;
  logic        counting;
  logic        pwr_end, dly_end;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  load_data;
  logic        load_rs;

  lcd_char_ram u_char_ram (
    .clk     (iCLK),
    .wr_en   (iWR_EN),
    .wr_addr (iWR_ADDR),
    .wr_data (iWR_DATA),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_addr   = step_char_addr(step);
  assign done_rise = done_q & ~done_qq;
  assign counting  = (state == PWRUP) || (state == DELAY);
  assign pwr_end   = (cnt == PWR_LAST);
  assign dly_end   = (cnt == DLY_LAST);

  always_comb begin
    load_data = rd_data;
    load_rs   = 1'b1;
    if (step <= STEP_INIT_LAST) begin
      load_rs = 1'b0;
      unique case (step[1:0])
        2'd0: load_data = CMD_FUNC_SET;
        2'd1: load_data = CMD_DISP_ON;
        2'd2: load_data = CMD_CLEAR;
        2'd3: load_data = CMD_ENTRY;
      endcase
    end else if (step == STEP_LINE1) begin
      load_data = ADDR_LINE1;
      load_rs   = 1'b0;
    end else if (step == STEP_LINE2) begin
      load_data = ADDR_LINE2;
      load_rs   = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      PWRUP: if (pwr_end) state_next = LOAD;
      LOAD:  state_next = START;
      START: state_next = WAIT;
      WAIT:  if (done_rise) state_next = DELAY;
      DELAY: if (dly_end) state_next = (step == STEP_LAST) ? IDLE : LOAD;
      IDLE:  if (iREFRESH || pending) state_next = LOAD;
      default: state_next = PWRUP;
    endcase
  end

  // Done-level edge detector powers up as "high" so a level already present is never mistaken for a rise.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state     <= PWRUP;
      cnt       <= '0;
      step      <= '0;
      pending   <= 1'b0;
      init_done <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_rs    <= 1'b0;
      done_q    <= 1'b1;
      done_qq   <= 1'b1;
    end else begin
      state   <= state_next;
      done_q  <= iLCD_DONE;
      done_qq <= done_q;
      cnt     <= (counting && state_next == state) ? cnt + 20'd1 : '0;
      if (state == LOAD) begin
        lcd_data <= load_data;
        lcd_rs   <= load_rs;
      end
      if (state == DELAY && state_next == LOAD) step <= step + 6'd1;
      if (state == IDLE && state_next == LOAD) step <= STEP_LINE1;
      if (state == IDLE) pending <= 1'b0;
      else if (iREFRESH) pending <= 1'b1;
      if (state == DELAY && dly_end && step == STEP_INIT_LAST) init_done <= 1'b1;
    end
  end

  assign oBUSY      = (state != IDLE);
  assign oINIT_DONE = init_done;
  assign oLCD_DATA  = lcd_data;
  assign oLCD_RS    = lcd_rs;
  assign oLCD_START = (state == START);

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a write-controller model that answers 20 cycles after each start.
module tb_lcd_sequencer;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iWR_EN = 1'b0;
  logic [4:0] iWR_ADDR = '0;
  logic [7:0] iWR_DATA = '0;
  logic       iREFRESH = 1'b0;
  logic       iLCD_DONE;
  logic       oBUSY, oINIT_DONE, oLCD_RS, oLCD_START;
  logic [7:0] oLCD_DATA;

  logic       model_done = 1'b0;
  int         mcnt = 0;
  logic       manual = 1'b0;
  logic       manual_done = 1'b0;

  logic [7:0] log_data[$];
  logic       log_rs[$];
  logic       log_init[$];
  logic [7:0] cbuf[32];

  int n_checks = 0;
  int n_fails  = 0;

  assign iLCD_DONE = manual ? manual_done : model_done;

  lcd_sequencer #(.POWERUP_CYCLES(10), .DELAY_CYCLES(4)) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iWR_EN     (iWR_EN),
    .iWR_ADDR   (iWR_ADDR),
    .iWR_DATA   (iWR_DATA),
    .iREFRESH   (iREFRESH),
    .oBUSY      (oBUSY),
    .oINIT_DONE (oINIT_DONE),
    .oLCD_DATA  (oLCD_DATA),
    .oLCD_RS    (oLCD_RS),
    .oLCD_START (oLCD_START),
    .iLCD_DONE  (iLCD_DONE)
  );

  always #5 iCLK = ~iCLK;

  // Transfer logger and write-controller model.
  always @(posedge iCLK) begin
    if (oLCD_START) begin
      log_data.push_back(oLCD_DATA);
      log_rs.push_back(oLCD_RS);
      log_init.push_back(oINIT_DONE);
      model_done <= 1'b0;
      mcnt       <= 20;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) model_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_rs.delete();
    log_init.delete();
  endtask

  task automatic pulse_refresh();
    iREFRESH = 1'b1;
    tick(1);
    iREFRESH = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] data);
    iWR_EN   = 1'b1;
    iWR_ADDR = addr;
    iWR_DATA = data;
    tick(1);
    iWR_EN   = 1'b0;
    cbuf[addr] = data;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (log_data.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(log_data.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    tick(1);
    while (oBUSY && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(oBUSY), 32'd0);
  endtask

  // Expected {rs, byte} for a given step of the list, using the bench's copy of the buffer.
  function automatic logic [8:0] exp_step(input int s);
    case (s)
      0:  return {1'b0, 8'h38};
      1:  return {1'b0, 8'h0C};
      2:  return {1'b0, 8'h01};
      3:  return {1'b0, 8'h06};
      4:  return {1'b0, 8'h80};
      21: return {1'b0, 8'hC0};
      default: return (s < 21) ? {1'b1, cbuf[s-5]} : {1'b1, cbuf[s-6]};
    endcase
  endfunction

  task automatic check_pass(input string name, input int first_step, input int count);
    check({name, "_count"}, 32'(log_data.size()), 32'(count));
    for (int i = 0; i < log_data.size() && i < count; i++) begin
      logic [8:0] e;
      e = exp_step(first_step + i);
      check($sformatf("%s_data%0d", name, i), 32'(log_data[i]), 32'(e[7:0]));
      check($sformatf("%s_rs%0d", name, i), 32'(log_rs[i]), 32'(e[8]));
    end
  endtask

  task automatic apply_reset(input string tag);
    iRST_N = 1'b0;
    tick(1);
    check({tag, "_rst_busy"}, 32'(oBUSY), 32'd1);
    check({tag, "_rst_init"}, 32'(oINIT_DONE), 32'd0);
    check({tag, "_rst_data"}, 32'(oLCD_DATA), 32'h00);
    check({tag, "_rst_rs"}, 32'(oLCD_RS), 32'd0);
    check({tag, "_rst_start"}, 32'(oLCD_START), 32'd0);
    tick(1);
    clear_log();
    iRST_N = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      if (k == 10) check({tag, "_start_early"}, 32'(oLCD_START), 32'd0);
    end
    check({tag, "_start_at11"}, 32'(oLCD_START), 32'd1);
    check({tag, "_first_data"}, 32'(oLCD_DATA), 32'h38);
    check({tag, "_first_rs"}, 32'(oLCD_RS), 32'd0);
    check({tag, "_pwrup_quiet"}, 32'(log_data.size()), 32'd0);
    check({tag, "_init_low"}, 32'(oINIT_DONE), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) cbuf[i] = 8'h20;

    // Power-up pass with three merged refresh requests arriving mid-pass.
    apply_reset("por");
    tick(100);
    pulse_refresh();
    tick(200);
    pulse_refresh();
    tick(200);
    pulse_refresh();
    wait_idle(3000, "init_idle");
    check_pass("init", 0, 38);
    if (log_init.size() >= 5) begin
      check("init_done_step3", 32'(log_init[3]), 32'd0);
      check("init_done_step4", 32'(log_init[4]), 32'd1);
    end
    check("init_done_level", 32'(oINIT_DONE), 32'd1);

    clear_log();
    wait_idle(3000, "merge_idle");
    check_pass("merge", 4, 34);
    tick(200);
    check("merge_no_extra", 32'(log_data.size()), 32'd34);
    check("merge_idle_hold", 32'(oBUSY), 32'd0);

    // Buffer writes in IDLE show up in the next refresh.
    wr(5'd16, 8'h41);
    wr(5'd3, 8'h42);
    clear_log();
    pulse_refresh();
    wait_idle(3000, "refresh_idle");
    check_pass("refresh", 4, 34);
    if (log_data.size() >= 19) begin
      check("refresh_after_c0", 32'(log_data[18]), 32'h41);
      check("refresh_char3", 32'(log_data[4]), 32'h42);
    end

    // Stale done level must not advance the sequencer.
    manual_done = 1'b1;
    manual = 1'b1;
    tick(3);
    clear_log();
    pulse_refresh();
    wait_starts(1, 20, "hold_first_start");
    tick(60);
    check("hold_no_advance", 32'(log_data.size()), 32'd1);
    check("hold_busy", 32'(oBUSY), 32'd1);
    manual_done = 1'b0;
    tick(2);
    manual_done = 1'b1;
    wait_starts(2, 40, "hold_fresh_edge");
    manual = 1'b0;
    wait_idle(3000, "hold_idle");
    check_pass("hold", 4, 34);

    // Reset while waiting on step 12 restarts the whole list; buffer survives.
    clear_log();
    pulse_refresh();
    wait_starts(9, 400, "mid_reach_step12");
    tick(5);
    apply_reset("mid");
    wait_idle(3000, "restart_idle");
    check_pass("restart", 0, 38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
